// File: rtl/uart_receiver.sv
// UART receiver: oversampled mid-bit sampling of an idle-high rx line into DBITS-wide words,
// with a one-cycle data_ready strobe, framing-error strobe and break (held-low line) handling.
module uart_receiver #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             rx,
    output logic [DBITS-1:0] data_out,
    output logic             data_ready,
    output logic             framing_error,
    output logic             busy
);

    // The tick counter must also reach SB_TICK-1, which can exceed OVS-1 for 1.5/2 stop bits.
    localparam int SW_BASE = $clog2(OVS) + 1;
    localparam int SW      = (SW_BASE > $clog2(SB_TICK)) ? SW_BASE : $clog2(SB_TICK);
    localparam int NW      = $clog2(DBITS);

    localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [DBITS-1:0] shreg_q, shreg_d;
    logic [DBITS-1:0] data_q, data_d;
    logic             ready_q, ready_d;
    logic             ferr_q, ferr_d;
    logic [1:0]       sync_q;
    logic             rx_sync;

    assign rx_sync = sync_q[1];

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            sync_q  <= {sync_q[0], rx};
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (sample_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_sync) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    if (s_q == S_BIT) begin
                        shreg_d = {rx_sync, shreg_q[DBITS-1:1]};
                        s_d     = '0;
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    if (s_q == S_STOP) begin
                        if (rx_sync) begin
                            data_d  = shreg_q;
                            ready_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            // A line held low after a bad stop bit must not decode as a stream of zero bytes.
            ST_BREAK: begin
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_out      = data_q;
    assign data_ready    = ready_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a tick-counting frame model predicts the exact cycle of
// every strobe and busy window; a per-cycle compare process checks the DUT against it.
module tb_uart_receiver;

    localparam int          OVS   = 16;
    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       rx;
    logic       rx7;
    logic [7:0] data_out;
    logic       data_ready, framing_error, busy;
    logic [6:0] data_out7;
    logic       data_ready7, framing_error7, busy7;

    uart_receiver u_dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .rx            (rx),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .busy          (busy)
    );

    uart_receiver #(.DBITS(7), .SB_TICK(32), .OVS(16)) u_dut7 (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .rx            (rx7),
        .data_out      (data_out7),
        .data_ready    (data_ready7),
        .framing_error (framing_error7),
        .busy          (busy7)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Expected strobe events and busy windows, in absolute posedge numbers.
    typedef struct {
        int unsigned cyc;
        bit          is_fe;
        logic [7:0]  data;
    } ev_t;
    typedef struct {
        int unsigned from_c;
        int unsigned to_c;
    } win_t;

    ev_t         evq[$];
    win_t        bq[$];
    int unsigned cyc      = 0;
    int unsigned tick_div = 4;
    bit          sel7     = 1'b0;
    bit          run_cmp  = 1'b1;
    logic [7:0]  exp_data = 8'h00;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_good   = 0;
    int          n_bad    = 0;

    int          dr_cnt = 0, fe_cnt = 0, busy_rise = 0, dr7_cnt = 0, fe7_cnt = 0;
    int unsigned last_dr_cyc = 0, last_busy_fall = 0, last_dr7_cyc = 0;
    logic [7:0]  last_dr_data = 8'h00;
    logic [6:0]  last_dr7_data = 7'h00;
    logic        prev_busy = 1'b0;
    bit          cmp_dr, cmp_fe, cmp_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive the pin and tick that the next posedge will sample, then step past that posedge.
    task automatic clk_step(input logic v);
        if (sel7) begin
            rx7 = v;
            rx  = 1'b1;
        end else begin
            rx  = v;
            rx7 = 1'b1;
        end
        sample_tick = ((cyc + 1) % tick_div == 0);
        @(posedge clk_100MHz);
        cyc++;
        #1;
    endtask

    // Posedge of the nth tick strictly after posedge e.
    function automatic int unsigned nth_tick(input int unsigned e, input int unsigned nth);
        return (e / tick_div + 1) * tick_div + (nth - 1) * tick_div;
    endfunction

    // A falling pin first sampled at posedge k is acted on at k+2; the receiver then needs
    // OVS/2 + nbits*OVS + sbt ticks, and the strobe is visible right after that tick.
    task automatic send_frame(input logic [8:0] d, input int nbits, input int sbt,
                              input bit stop_ok, input bit tight,
                              output int unsigned k, output int unsigned pt);
        int unsigned b;
        ev_t         ev;
        win_t        w;
        b  = OVS * tick_div;
        k  = cyc + 1;
        pt = nth_tick(k + 2, OVS / 2 + nbits * OVS + sbt);
        if (!sel7) begin
            w.from_c = k + 2;
            w.to_c   = stop_ok ? pt : NEVER;
            bq.push_back(w);
            ev.cyc   = pt;
            ev.is_fe = !stop_ok;
            ev.data  = d[7:0];
            evq.push_back(ev);
            if (stop_ok) n_good++;
            else         n_bad++;
        end
        repeat (b) clk_step(1'b0);
        for (int i = 0; i < nbits; i++) repeat (b) clk_step(d[i]);
        if (stop_ok) begin
            if (tight) begin
                while (cyc < pt - 2) clk_step(1'b1);
            end else begin
                repeat (sbt * tick_div) clk_step(1'b1);
            end
        end else begin
            repeat (sbt * tick_div + 5 * b) clk_step(1'b0);
            if (!sel7) bq[bq.size()-1].to_c = cyc + 3;
            clk_step(1'b1);
        end
    endtask

    task automatic glitch(input int unsigned len);
        int unsigned k, ph;
        win_t        w;
        k        = cyc + 1;
        ph       = nth_tick(k + 2, OVS / 2);
        w.from_c = k + 2;
        w.to_c   = ph;
        bq.push_back(w);
        repeat (len) clk_step(1'b0);
        while (cyc < ph) clk_step(1'b1);
    endtask

    task automatic abort_frame_with_reset();
        int unsigned b;
        logic [7:0]  d;
        win_t        w;
        b        = OVS * tick_div;
        d        = 8'h7E;
        w.from_c = cyc + 3;
        w.to_c   = NEVER;
        bq.push_back(w);
        repeat (b) clk_step(1'b0);
        for (int i = 0; i < 4; i++) repeat (b) clk_step(d[i]);
        repeat (b / 2) clk_step(d[4]);
        reset = 1'b1;
        bq.delete();
        evq.delete();
        exp_data = 8'h00;
        repeat (3) clk_step(1'b1);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_framing_error", framing_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (5) clk_step(1'b1);
    endtask

    // Per-cycle comparison against the model, plus strobe bookkeeping for directed checks.
    always @(negedge clk_100MHz) begin
        if (run_cmp) begin
            cmp_dr   = 1'b0;
            cmp_fe   = 1'b0;
            cmp_busy = 1'b0;
            while (bq.size() > 0 && cyc >= bq[0].to_c) bq.delete(0);
            if (bq.size() > 0 && cyc >= bq[0].from_c) cmp_busy = 1'b1;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                if (evq[0].is_fe) begin
                    cmp_fe = 1'b1;
                end else begin
                    cmp_dr   = 1'b1;
                    exp_data = evq[0].data;
                end
                evq.delete(0);
            end
            check("data_ready", data_ready, cmp_dr);
            check("framing_error", framing_error, cmp_fe);
            check("busy", busy, cmp_busy);
            check("data_out", data_out, exp_data);

            if (data_ready) begin
                dr_cnt++;
                last_dr_cyc  = cyc;
                last_dr_data = data_out;
            end
            if (framing_error) fe_cnt++;
            if (busy && !prev_busy) busy_rise++;
            if (!busy && prev_busy) last_busy_fall = cyc;
            prev_busy = busy;
            if (data_ready7) begin
                dr7_cnt++;
                last_dr7_cyc  = cyc;
                last_dr7_data = data_out7;
            end
            if (framing_error7) fe7_cnt++;
        end
    end

    initial begin
        int unsigned k, pt;
        int          base_dr, base_fe, base_rise, base_dr7;
        logic [8:0]  rb, rb2;

        reset       = 1'b1;
        rx          = 1'b1;
        rx7         = 1'b1;
        sample_tick = 1'b0;
        repeat (4) clk_step(1'b1);
        check("init_data_out", data_out, 8'h00);
        check("init_busy", busy, 1'b0);
        check("init_data_out7", data_out7, 7'h00);
        check("init_busy7", busy7, 1'b0);
        reset = 1'b0;
        repeat (10) clk_step(1'b1);

        // Single 0x55 frame, tick every 4 clocks.
        base_dr = dr_cnt;
        send_frame(9'h055, 8, 16, 1'b1, 1'b0, k, pt);
        repeat (20) clk_step(1'b1);
        check("f55_pulses", dr_cnt - base_dr, 1);
        check("f55_data", last_dr_data, 8'h55);
        check("f55_latency", (last_dr_cyc - k >= 602) && (last_dr_cyc - k <= 618), 1'b1);
        check("f55_busy_fall", last_busy_fall, last_dr_cyc);

        // Back-to-back frames with no idle gap, then a pair whose start edge follows the stop sample.
        base_dr = dr_cnt;
        base_fe = fe_cnt;
        send_frame(9'h0A3, 8, 16, 1'b1, 1'b0, k, pt);
        send_frame(9'h00F, 8, 16, 1'b1, 1'b0, k, pt);
        repeat (10) clk_step(1'b1);
        check("b2b_data", data_out, 8'h0F);
        send_frame(9'h096, 8, 16, 1'b1, 1'b1, k, pt);
        send_frame(9'h03C, 8, 16, 1'b1, 1'b0, k, pt);
        repeat (10) clk_step(1'b1);
        check("b2b_pulses", dr_cnt - base_dr, 4);
        check("b2b_no_ferr", fe_cnt - base_fe, 0);
        check("tight_data", data_out, 8'h3C);

        // Short start-bit glitch.
        base_dr   = dr_cnt;
        base_fe   = fe_cnt;
        base_rise = busy_rise;
        glitch(12);
        repeat (10) clk_step(1'b1);
        check("glitch_busy_pulse", busy_rise - base_rise, 1);
        check("glitch_no_ready", dr_cnt - base_dr, 0);
        check("glitch_no_ferr", fe_cnt - base_fe, 0);

        // Bad stop bit followed by a long break.
        base_dr = dr_cnt;
        base_fe = fe_cnt;
        send_frame(9'h0C4, 8, 16, 1'b0, 1'b0, k, pt);
        check("c4_busy_in_break", busy, 1'b1);
        repeat (10) clk_step(1'b1);
        check("c4_ferr_pulses", fe_cnt - base_fe, 1);
        check("c4_no_ready", dr_cnt - base_dr, 0);
        check("c4_data_kept", data_out, 8'h3C);
        check("c4_busy_after", busy, 1'b0);

        // Reset during data bit 4, then a clean frame.
        base_dr = dr_cnt;
        abort_frame_with_reset();
        send_frame(9'h081, 8, 16, 1'b1, 1'b0, k, pt);
        repeat (10) clk_step(1'b1);
        check("after_rst_pulses", dr_cnt - base_dr, 1);
        check("after_rst_data", data_out, 8'h81);

        // Seven data bits, two stop bits.
        base_dr7 = dr7_cnt;
        sel7     = 1'b1;
        send_frame(9'h02A, 7, 32, 1'b1, 1'b0, k, pt);
        repeat (20) clk_step(1'b1);
        sel7 = 1'b0;
        check("d7_pulses", dr7_cnt - base_dr7, 1);
        check("d7_data", data_out7, 7'h2A);
        check("d7_pulse_cycle", last_dr7_cyc, pt);
        check("d7_latency", (last_dr7_cyc - k >= 607) && (last_dr7_cyc - k <= 610), 1'b1);
        check("d7_no_ferr", fe7_cnt, 0);

        // Randomized traffic over several tick rates, including a tick on every clock.
        for (int it = 0; it < 48; it++) begin
            tick_div = $urandom_range(1, 4);
            rb       = 9'($urandom_range(0, 255));
            rb2      = 9'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: send_frame(rb, 8, 16, 1'b1, 1'b0, k, pt);
                5, 6: begin
                    send_frame(rb, 8, 16, 1'b1, 1'b1, k, pt);
                    send_frame(rb2, 8, 16, 1'b1, 1'b0, k, pt);
                end
                7: send_frame(rb, 8, 16, 1'b0, 1'b0, k, pt);
                8: glitch($urandom_range(1, 3 * tick_div));
                default: repeat ($urandom_range(50, 200)) clk_step(1'b1);
            endcase
            repeat ($urandom_range(3, 25)) clk_step(1'b1);
        end

        repeat (30) clk_step(1'b1);
        check("total_ready_pulses", dr_cnt, n_good);
        check("total_ferr_pulses", fe_cnt, n_bad);
        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
